// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: reset-sequencer state codes and counter sizing helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package clk_rst_pkg;

    // State codes are visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } rst_state_t;

    // Bits needed for a counter running 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clock cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk (sampling clock), rst_n (async active-low, clears chain),
//        d (async input), q (synchronised output, 0 in reset).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL-lock driven reset sequencer: synchronise, filter, stretch, then release sys_reset_n and run a CE divider.
// Latency: lock seen SYNC_STAGES cycles after locked; sys_reset_n rises one cycle after entering RUN.
// Backpressure: none; lock loss forces WAIT_LOCK with priority over every other transition.
// Ports: clock_in (PLL clock), reset_n (async active-low), locked (async PLL lock),
//        sys_reset_n (async-assert / sync-deassert system reset), cpu_ce (enable strobe),
//        lock_lost (sticky), state (FSM code).
// Build option: PLL_RESET_LOSS_COUNT_EN adds loss_count[7:0], a saturating lock-loss counter.
module pll_reset_ctrl
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int CE_DIV      = 276
) (
`ifdef PLL_RESET_LOSS_COUNT_EN
    output logic [7:0] loss_count,
`endif
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    output logic       sys_reset_n,
    output logic       cpu_ce,
    output logic       lock_lost,
    output logic [1:0] state
);

    localparam int FW = cnt_width(LOCK_FILTER);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int CW = cnt_width(CE_DIV);

    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CE_LAST   = CW'(CE_DIV - 1);

    logic            lock_s;
    rst_state_t      state_q;
    rst_state_t      state_next;
    logic [FW-1:0]   filt_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   ce_cnt;
    logic            sys_rst_q;
    logic            lost_q;
    logic            loss_evt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (locked),
        .q     (lock_s)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_next;
        end
    end

    // A dropped lock outranks every other move, so it is tested first.
    always_comb begin
        state_next = state_q;
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: if (lock_s)                state_next = FILTER;
                FILTER:    if (filt_cnt == FILT_LAST) state_next = HOLD;
                HOLD:      if (hold_cnt == HOLD_LAST) state_next = RUN;
                RUN:                                  state_next = RUN;
                default:                              state_next = WAIT_LOCK;
            endcase
        end
    end

    assign loss_evt = (state_q == RUN) && !lock_s;

    // Each counter is held at zero outside its own state, so entering a state
    // always starts a fresh count; counters never move past their last value.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt  <= '0;
            hold_cnt  <= '0;
            ce_cnt    <= '0;
            sys_rst_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            if (state_q == FILTER && state_next == FILTER && filt_cnt != FILT_LAST)
                filt_cnt <= filt_cnt + 1'b1;
            else
                filt_cnt <= '0;

            if (state_q == HOLD && state_next == HOLD && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;

            // Divider restarts at its terminal value to give a periodic strobe.
            if (state_q == RUN && state_next == RUN && ce_cnt != CE_LAST)
                ce_cnt <= ce_cnt + 1'b1;
            else
                ce_cnt <= '0;

            sys_rst_q <= (state_q == RUN);
            lost_q    <= lost_q | loss_evt;
        end
    end

`ifdef PLL_RESET_LOSS_COUNT_EN
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_count <= '0;
        end else if (loss_evt && loss_count != 8'hFF) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`endif

    // Gated by lock_s so no strobe escapes on the final RUN cycle before exit.
    assign cpu_ce      = (state_q == RUN) && lock_s && (ce_cnt == CE_LAST);
    assign sys_reset_n = sys_rst_q;
    assign lock_lost   = lost_q;
    assign state       = state_q;

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for locked, minimum 2.
REQ-002 SHALL have parameter LOCK_FILTER, default 16: consecutive synchronised-locked cycles required, minimum 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1024: reset stretch after filter, minimum 1.
REQ-004 SHALL have parameter CE_DIV, default 276: clock-enable divide ratio (276 MHz to 1 MHz), minimum 1.
REQ-005 SHALL have port clock_in, input, 1: the single clock (PLL output); all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port locked, input, 1: PLL lock, asynchronous to clock_in.
REQ-008 SHALL have port sys_reset_n, output, 1: active-low system reset, asserted asynchronously, deasserted synchronously.
REQ-009 SHALL have port cpu_ce, output, 1: one-cycle clock-enable strobe.
REQ-010 SHALL have port lock_lost, output, 1: sticky flag, lock dropped while in RUN.
REQ-011 SHALL have port state, output, 2: current FSM state code.

Function
REQ-012 SHALL pass locked through a SYNC_STAGES flip-flop chain; only the last stage (lock_s) drives logic.
REQ-013 SHALL implement states WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3.
REQ-014 SHALL transition WAIT_LOCK to FILTER when lock_s=1, clearing the filter counter.
REQ-015 SHALL in FILTER count cycles with lock_s=1 and enter HOLD on the cycle the count reaches LOCK_FILTER.
REQ-016 SHALL in HOLD count HOLD_CYCLES cycles, then enter RUN.
REQ-017 SHALL from FILTER, HOLD or RUN return to WAIT_LOCK on the cycle after lock_s=0; the lock_s=0 check takes priority over all other transitions.
REQ-018 SHALL drive sys_reset_n=1 only while in RUN, registered, so it rises one cycle after entering RUN and falls one cycle after leaving it.
REQ-019 SHALL set lock_lost on a RUN-to-WAIT_LOCK transition; it clears only on reset_n.
REQ-020 SHALL clear the CE counter on entering RUN and pulse cpu_ce on the CE_DIV-th, 2*CE_DIV-th, ... RUN cycle; CE_DIV=1 holds cpu_ce=1 throughout RUN.
REQ-021 SHALL hold cpu_ce=0 outside RUN, including the cycle of exit.
REQ-022 SHALL size counters with $clog2 of their parameter; no counter wraps, each stops at its terminal count.

Reset
REQ-023 SHALL, on reset_n=0, asynchronously force state=WAIT_LOCK, sync chain=0, all counters=0, sys_reset_n=0, cpu_ce=0, lock_lost=0.
REQ-024 SHALL, on reset_n release mid-lock, restart from WAIT_LOCK; the full filter and hold sequence runs again.

Configuration
REQ-025 SHALL, with macro PLL_RESET_LOSS_COUNT_EN defined, add output loss_count[7:0]: saturating (stops at 255) count of lock_lost events, cleared by reset_n.
REQ-026 SHALL, without PLL_RESET_LOSS_COUNT_EN, omit the loss_count port and counter; all other behaviour is identical.

Structure
REQ-027 SHALL take state encodings and the 2-bit state type from shared package clk_rst_pkg.
REQ-028 SHALL place the synchroniser in sub-module sync_ff (parameter STAGES, async active-low reset, output reset to 0), reusable elsewhere.

Verification (LOCK_FILTER=4, HOLD_CYCLES=8, CE_DIV=3, SYNC_STAGES=2)
REQ-029 SHALL check power-up: locked rises at cycle 0 -> lock_s=1 at cycle 2, HOLD at cycle 7, RUN at cycle 15, sys_reset_n=1 at cycle 16.
REQ-030 SHALL check glitch: locked high 2 cycles then low during FILTER -> state returns to WAIT_LOCK, sys_reset_n stays 0, lock_lost stays 0.
REQ-031 SHALL check CE: in RUN -> cpu_ce pulses on RUN cycles 3, 6, 9, each exactly one cycle wide.
REQ-032 SHALL check lock loss: in RUN, drop locked -> sys_reset_n=0 within SYNC_STAGES+2 cycles, lock_lost=1, cpu_ce=0; relock -> full sequence repeats, lock_lost remains 1.
REQ-033 SHALL check async reset: assert reset_n mid-HOLD between clock edges -> all outputs 0 immediately, without waiting for an edge.
REQ-034 SHALL check the macro: with PLL_RESET_LOSS_COUNT_EN defined, 300 lock-loss events -> loss_count=255.
